smod_rr_sched: RTL

Round-robin scheduler that shares one iterative signed-modulo (SMOD) resource between NREQ requesters in the generated datapaths. Scheduled datapath controllers send a (a % b) job through a valid/ready port. The block arbitrates between requesters, runs the job bit-serially, and returns the remainder tagged with the requester ID. It replaces one combinational SMOD instance per datapath with one shared multi-cycle unit.

---
 rtl/smod_pkg.sv | 41 ++++
 rtl/smod_iter_core.sv | 78 +++++++
 rtl/smod_rr_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/smod_pkg.sv
// Shared types and helpers for the round-robin signed-modulo scheduler.
// Holds the FSM encoding, the rotating-priority pick and the conditional negate.
package smod_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int MAXREQ = 16;
    localparam int MAXW   = 128;

    // First set bit of valid, scanning upward from ptr+1 and wrapping at nreq.
    function automatic logic [3:0] rr_next(input logic [MAXREQ-1:0] valid,
                                           input logic [3:0]        ptr,
                                           input int                nreq);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MAXREQ; i++) begin
            idx = 4'((int'(ptr) + i) % nreq);
            if (i <= nreq && !found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Callers zero-extend into MAXW and truncate back, so the result is the
    // two's-complement negate at their own width.
    function automatic logic [MAXW-1:0] cond_neg(input logic            neg,
                                                 input logic [MAXW-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/smod_iter_core.sv
// Bit-serial restoring divider on unsigned magnitudes; one quotient bit per edge.
// After start, done is high during the W-th step and rem is valid once busy drops.
module smod_iter_core
    import smod_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] abs_a,
    input  logic [W-1:0] abs_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rem
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, b_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = abs_a;
            b_d    = abs_b;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // quo_q shifts the dividend out at the top and the quotient in at the bottom.
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(W - 1));
    assign rem  = rem_q;

endmodule

// File: rtl/smod_rr_sched.sv
// Shares one iterative signed-modulo unit among NREQ requesters with round-robin arbitration.
// Handshake: a transfer happens on an edge where valid and ready are both high; valid holds until then.
module smod_rr_sched
    import smod_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int NREQ      = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] req_a,
    input  logic [NREQ*DATAWIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [IDW-1:0]            resp_id,
    output logic [DATAWIDTH-1:0]      resp_z,
    output logic                      resp_dz,
    output state_e                    dbg_state
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 sign_q, sign_d;
    logic [DATAWIDTH-1:0] z_q, z_d;
    logic                 dz_q, dz_d;

    logic [IDW-1:0]       grant_idx;
    logic                 accept;
    logic [DATAWIDTH-1:0] sel_a, sel_b;
    logic [DATAWIDTH-1:0] abs_a, abs_b;
    logic                 b_zero;
    logic                 core_start, core_busy, core_done;
    logic [DATAWIDTH-1:0] core_rem;

    // Any valid bit guarantees a grant, so acceptance needs no found flag.
    always_comb begin
        grant_idx  = IDW'(rr_next(MAXREQ'(req_valid), 4'(ptr_q), NREQ));
        accept     = (state_q == S_IDLE) && (|req_valid);
        sel_a      = req_a[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
        sel_b      = req_b[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
        b_zero     = (sel_b == '0);
        abs_a      = DATAWIDTH'(cond_neg(sel_a[DATAWIDTH-1], MAXW'(sel_a)));
        abs_b      = DATAWIDTH'(cond_neg(sel_b[DATAWIDTH-1], MAXW'(sel_b)));
        core_start = accept && !b_zero;
    end

    smod_iter_core #(
        .W(DATAWIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst),
        .start (core_start),
        .abs_a (abs_a),
        .abs_b (abs_b),
        .busy  (core_busy),
        .done  (core_done),
        .rem   (core_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = b_zero ? S_RESP : S_CALC;
            S_CALC: if (core_done) state_d = S_FIX;
            S_FIX:  state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates ready so no grant is visible while rst is held low.
    always_comb begin
        req_ready  = (accept && rst) ? (NREQ'(1) << grant_idx) : '0;
        resp_valid = (state_q == S_RESP);
        dbg_state  = state_q;
    end

    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        sign_d = sign_q;
        z_d    = z_q;
        dz_d   = dz_q;
        if (accept) begin
            ptr_d  = grant_idx;
            id_d   = grant_idx;
            sign_d = sel_a[DATAWIDTH-1];
            dz_d   = b_zero;
            if (b_zero) begin
                z_d = '0;
            end
        end
        // The remainder takes the sign of the dividend.
        if (state_q == S_FIX && !core_busy) begin
            z_d  = DATAWIDTH'(cond_neg(sign_q, MAXW'(core_rem)));
            dz_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= IDW'(NREQ - 1);
            id_q   <= '0;
            sign_q <= 1'b0;
            z_q    <= '0;
            dz_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            sign_q <= sign_d;
            z_q    <= z_d;
            dz_q   <= dz_d;
        end
    end

    assign resp_id = id_q;
    assign resp_z  = z_q;
    assign resp_dz = dz_q;

endmodule
